// File: rtl/sc_regwrarb_pkg.sv
// Shared definitions for the general-purpose register bank write-port arbiter.
// Holds the FSM state encoding and the default bus and bank dimensions.
package sc_regwrarb_pkg;

    localparam int unsigned DATAWIDTH_BUS = 32;
    localparam int unsigned REGADDR_WIDTH = 5;
    localparam int unsigned NUM_REQ       = 3;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } sc_regwrarb_state_e;

endpackage

// File: rtl/sc_rr_picker.sv
// Combinational round-robin selector: the first asserted request found when
// scanning upward from i_rr_ptr, wrapping from NUM_REQ-1 back to 0.
module sc_rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_winner,
    output logic               o_valid
);

    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                   input logic [PTR_W-1:0]   ptr);
        logic [NUM_REQ-1:0] grant;
        logic               found;
        int unsigned        k;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[k[PTR_W-1:0]]) begin
                grant[k[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return grant;
    endfunction

    assign o_winner = rr_pick(i_req, i_rr_ptr);
    assign o_valid  = |i_req;

endmodule

// File: rtl/sc_regwrite_arbiter.sv
// Round-robin write-port arbiter for the register bank: grants one requester per
// two cycles and drives registered one-cold write strobes plus the shared data bus.
module sc_regwrite_arbiter
    import sc_regwrarb_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS = sc_regwrarb_pkg::DATAWIDTH_BUS,
    parameter int unsigned REGADDR_WIDTH = sc_regwrarb_pkg::REGADDR_WIDTH,
    parameter int unsigned NUM_REQ       = sc_regwrarb_pkg::NUM_REQ
) (
    input  logic                              SC_RegWRARB_CLOCK_50,
    input  logic                              SC_RegWRARB_RESET_InLow,
    input  logic                              SC_RegWRARB_Hold_InHigh,
    input  logic [NUM_REQ-1:0]                SC_RegWRARB_Req_InHigh,
    input  logic [NUM_REQ*REGADDR_WIDTH-1:0]  SC_RegWRARB_Addr_In,
    input  logic [NUM_REQ*DATAWIDTH_BUS-1:0]  SC_RegWRARB_Data_In,
    output logic [NUM_REQ-1:0]                SC_RegWRARB_Grant_OutHigh,
    output logic [(2**REGADDR_WIDTH)-1:0]     SC_RegWRARB_Write_OutLow,
    output logic [DATAWIDTH_BUS-1:0]          SC_RegWRARB_DataBUS_Out,
    output logic                              SC_RegWRARB_Busy_OutHigh
);

    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NUM_REG = 2 ** REGADDR_WIDTH;

    sc_regwrarb_state_e       r_state, w_state_d;
    logic [PTR_W-1:0]         r_rr_ptr, w_rr_ptr_d;
    logic [NUM_REQ-1:0]       r_grant, w_grant_d;
    logic [NUM_REG-1:0]       r_write_n, w_write_n_d;
    logic [DATAWIDTH_BUS-1:0] r_data, w_data_d;

    logic [NUM_REQ-1:0]       w_winner;
    logic                     w_valid;
    logic [PTR_W-1:0]         w_win_idx;
    logic [REGADDR_WIDTH-1:0] w_win_addr;
    logic [DATAWIDTH_BUS-1:0] w_win_data;

    sc_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req    (SC_RegWRARB_Req_InHigh),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Mux the winner's index, address and data out of the packed request buses.
    always_comb begin
        w_win_idx  = '0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_winner[i]) begin
                w_win_idx  = PTR_W'(i);
                w_win_addr = SC_RegWRARB_Addr_In[i*REGADDR_WIDTH +: REGADDR_WIDTH];
                w_win_data = SC_RegWRARB_Data_In[i*DATAWIDTH_BUS +: DATAWIDTH_BUS];
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_rr_ptr_d  = r_rr_ptr;
        w_grant_d   = '0;
        w_write_n_d = '1;
        w_data_d    = r_data;
        unique case (r_state)
            StIdle: begin
                if (!SC_RegWRARB_Hold_InHigh && w_valid) begin
                    w_state_d = StGrant;
                    w_grant_d = w_winner;
                    w_data_d  = w_win_data;
                    // r0 is hardwired zero: the grant is consumed but never strobed.
                    if (w_win_addr != '0) begin
                        w_write_n_d[w_win_addr] = 1'b0;
                    end
                    w_rr_ptr_d = (w_win_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                     : w_win_idx + PTR_W'(1);
                end
            end
            StGrant: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge SC_RegWRARB_CLOCK_50 or negedge SC_RegWRARB_RESET_InLow) begin
        if (!SC_RegWRARB_RESET_InLow) begin
            r_state   <= StIdle;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_write_n <= '1;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_d;
            r_rr_ptr  <= w_rr_ptr_d;
            r_grant   <= w_grant_d;
            r_write_n <= w_write_n_d;
            r_data    <= w_data_d;
        end
    end

    assign SC_RegWRARB_Grant_OutHigh = r_grant;
    assign SC_RegWRARB_Write_OutLow  = r_write_n;
    assign SC_RegWRARB_DataBUS_Out   = r_data;
    assign SC_RegWRARB_Busy_OutHigh  = (r_state == StGrant);

endmodule

// File: tb/tb_sc_regwrite_arbiter.sv
// Directed bench for sc_regwrite_arbiter with a behavioural register bank that
// captures the data bus on any low strobe at the rising edge.
module tb_sc_regwrite_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NREG = 32;

    logic               clk;
    logic               rst_n;
    logic               hold;
    logic [NR-1:0]      req;
    logic [NR*AW-1:0]   addr;
    logic [NR*DW-1:0]   data;
    logic [NR-1:0]      grant;
    logic [NREG-1:0]    write_n;
    logic [DW-1:0]      databus;
    logic               busy;

    logic [DW-1:0]      bank [NREG] = '{default: '0};

    int n_checks = 0;
    int n_fail   = 0;

    sc_regwrite_arbiter #(
        .DATAWIDTH_BUS (DW),
        .REGADDR_WIDTH (AW),
        .NUM_REQ       (NR)
    ) dut (
        .SC_RegWRARB_CLOCK_50      (clk),
        .SC_RegWRARB_RESET_InLow   (rst_n),
        .SC_RegWRARB_Hold_InHigh   (hold),
        .SC_RegWRARB_Req_InHigh    (req),
        .SC_RegWRARB_Addr_In       (addr),
        .SC_RegWRARB_Data_In       (data),
        .SC_RegWRARB_Grant_OutHigh (grant),
        .SC_RegWRARB_Write_OutLow  (write_n),
        .SC_RegWRARB_DataBUS_Out   (databus),
        .SC_RegWRARB_Busy_OutHigh  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!write_n[i]) bank[i] <= databus;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[idx]             = 1'b1;
        addr[idx*AW +: AW]   = a;
        data[idx*DW +: DW]   = d;
    endtask

    function automatic logic [NREG-1:0] strobe(input int r);
        logic [NREG-1:0] s;
        s    = '1;
        s[r] = 1'b0;
        return s;
    endfunction

    localparam logic [NREG-1:0] ALL_ONES = '1;

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        req   = '0;
        addr  = '0;
        data  = '0;
        tick();
        check_eq("rst_grant", 64'(grant), 64'h0);
        check_eq("rst_wr", 64'(write_n), 64'(ALL_ONES));
        check_eq("rst_data", 64'(databus), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset asserted in the middle of a grant drops the write.
        set_req(1, 5'd5, 32'hDEADBEEF);
        tick();
        check_eq("midrst_pre_grant", 64'(grant), 64'b010);
        check_eq("midrst_pre_wr", 64'(write_n), 64'(strobe(5)));
        rst_n = 1'b0;
        req   = '0;
        #1;
        check_eq("midrst_grant", 64'(grant), 64'h0);
        check_eq("midrst_wr", 64'(write_n), 64'(ALL_ONES));
        check_eq("midrst_data", 64'(databus), 64'h0);
        check_eq("midrst_busy", 64'(busy), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("midrst_after_grant", 64'(grant), 64'h0);
        check_eq("midrst_bank5", 64'(bank[5]), 64'h0);

        // Single write from requester 0.
        set_req(0, 5'd7, 32'h12345678);
        tick();
        check_eq("single_grant", 64'(grant), 64'b001);
        check_eq("single_wr", 64'(write_n), 64'(strobe(7)));
        check_eq("single_data", 64'(databus), 64'h12345678);
        check_eq("single_busy", 64'(busy), 64'h1);
        req = '0;
        tick();
        check_eq("single_end_grant", 64'(grant), 64'h0);
        check_eq("single_end_wr", 64'(write_n), 64'(ALL_ONES));
        check_eq("single_hold_data", 64'(databus), 64'h12345678);
        check_eq("single_bank7", 64'(bank[7]), 64'h12345678);

        // Write to r0 is granted but not strobed; pointer moves from 1 past 2 to 0.
        set_req(2, 5'd0, 32'hFFFFFFFF);
        tick();
        check_eq("r0_grant", 64'(grant), 64'b100);
        check_eq("r0_wr", 64'(write_n), 64'(ALL_ONES));
        check_eq("r0_data", 64'(databus), 64'hFFFFFFFF);
        req = '0;
        tick();
        check_eq("r0_bank0", 64'(bank[0]), 64'h0);

        // All three held: grants 001, 010, 100, 001 with an idle cycle between.
        set_req(0, 5'd1, 32'hAAAA0001);
        set_req(1, 5'd2, 32'hBBBB0002);
        set_req(2, 5'd3, 32'hCCCC0003);
        tick();
        check_eq("rr_g0", 64'(grant), 64'b001);
        check_eq("rr_d0", 64'(databus), 64'hAAAA0001);
        tick();
        check_eq("rr_gap0", 64'(grant), 64'h0);
        tick();
        check_eq("rr_g1", 64'(grant), 64'b010);
        check_eq("rr_w1", 64'(write_n), 64'(strobe(2)));
        tick();
        check_eq("rr_gap1", 64'(grant), 64'h0);
        tick();
        check_eq("rr_g2", 64'(grant), 64'b100);
        check_eq("rr_d2", 64'(databus), 64'hCCCC0003);
        tick();
        check_eq("rr_gap2", 64'(grant), 64'h0);
        tick();
        check_eq("rr_g3", 64'(grant), 64'b001);
        req = '0;
        tick();
        check_eq("rr_bank1", 64'(bank[1]), 64'hAAAA0001);
        check_eq("rr_bank2", 64'(bank[2]), 64'hBBBB0002);
        check_eq("rr_bank3", 64'(bank[3]), 64'hCCCC0003);

        // Hold blocks a pending request until it drops.
        hold = 1'b1;
        set_req(1, 5'd9, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("hold_grant", 64'(grant), 64'h0);
            check_eq("hold_busy", 64'(busy), 64'h0);
        end
        hold = 1'b0;
        tick();
        check_eq("hold_rel_grant", 64'(grant), 64'b010);
        check_eq("hold_rel_wr", 64'(write_n), 64'(strobe(9)));
        req = '0;
        tick();
        check_eq("hold_bank9", 64'(bank[9]), 64'hCAFEF00D);

        // Hold raised inside GRANT lets the write finish and blocks the next one.
        set_req(0, 5'd4, 32'h0BADC0DE);
        tick();
        check_eq("hg_grant", 64'(grant), 64'b001);
        hold = 1'b1;
        tick();
        check_eq("hg_end_grant", 64'(grant), 64'h0);
        check_eq("hg_bank4", 64'(bank[4]), 64'h0BADC0DE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hg_blocked_grant", 64'(grant), 64'h0);
            check_eq("hg_blocked_busy", 64'(busy), 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
